// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } state_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC = 32'h0000_0100;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam int          DEF_CNT_W    = 32;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of branch-decision inputs and PC/trap/counter outputs of the sequencer.
// Latency: none (wires only).
// Backpressure: imem_ready/stall from the core hold the sequencer; no reverse flow.
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);

  logic             next_pc_src;
  logic [31:0]      alu_target;
  logic             imem_ready;
  logic             stall;
  logic             trap_clear;
  logic [31:0]      pc;
  logic [31:0]      pc_plus4;
  logic             imem_req;
  logic             trap;
  logic [31:0]      trap_addr;
  logic [CNT_W-1:0] instret;

  // Core side: drives the decision, consumes the PC and status.
  modport master (
    output next_pc_src, alu_target, imem_ready, stall, trap_clear,
    input  pc, pc_plus4, imem_req, trap, trap_addr, instret
  );

  // Sequencer side.
  modport slave (
    input  next_pc_src, alu_target, imem_ready, stall, trap_clear,
    output pc, pc_plus4, imem_req, trap, trap_addr, instret
  );

endinterface

// File: rtl/pc_target_check.sv
// Normalises a jump target (bit0 cleared, JALR style) and flags word misalignment.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever alu_target is.
module pc_target_check (
  input  logic [31:0] alu_target,
  output logic [31:0] tgt,
  output logic        misaligned
);

  // Bit0 is dropped first; what remains misaligned is bit1 only.
  always_comb begin
    tgt        = alu_target & ~32'h0000_0001;
    misaligned = tgt[1];
  end

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural PC: sequential/branch update, misaligned-target trap, retire counter.
// Latency: a decision presented in cycle N is visible on pc in cycle N+1.
// Backpressure: imem_ready low or stall high holds pc and instret; TRAP blocks commits until trap_clear.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEF_TRAP_VEC,
  parameter int          CNT_W    = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             trap_q, trap_d;
  logic [31:0]      trap_addr_q, trap_addr_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [31:0]      tgt;
  logic             misaligned;
  logic             commit;

  pc_target_check u_tgt_chk (
    .alu_target (bus.alu_target),
    .tgt        (tgt),
    .misaligned (misaligned)
  );

  // stall wins over imem_ready; only FETCH can retire an instruction.
  assign commit = (state_q == FETCH) && bus.imem_ready && !bus.stall;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, trap status and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      trap_q      <= 1'b0;
      trap_addr_q <= 32'h0000_0000;
      instret_q   <= '0;
    end else begin
      pc_q        <= pc_d;
      trap_q      <= trap_d;
      trap_addr_q <= trap_addr_d;
      instret_q   <= instret_d;
    end
  end

  // Next-state and datapath update; everything holds unless a commit or trap_clear acts.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_d      = trap_q;
    trap_addr_d = trap_addr_q;
    instret_d   = instret_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (commit) begin
          // The trapping instruction still counts as retired.
          instret_d = instret_q + CNT_ONE;
          if (bus.next_pc_src) begin
            if (misaligned) begin
              trap_d      = 1'b1;
              trap_addr_d = tgt;
              state_d     = TRAP;
            end else begin
              pc_d = tgt;
            end
          end else begin
            pc_d = pc_q + PC_INC;
          end
        end
      end
      TRAP: begin
        // trap_addr is left as a record of the last offending target.
        if (bus.trap_clear) begin
          pc_d    = TRAP_VEC;
          trap_d  = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_q + PC_INC;
  assign bus.imem_req  = (state_q == FETCH);
  assign bus.trap      = trap_q;
  assign bus.trap_addr = trap_addr_q;
  assign bus.instret   = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench with an expected-value queue and an independent negedge monitor.
// Latency: each vector's expectation describes the outputs visible during the cycle it is applied.
// Backpressure: not applicable.
module tb_pc_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_W(32)) bus();

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .TRAP_VEC (32'h0000_0100),
    .CNT_W    (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        trap;
    logic [31:0] taddr;
    logic [31:0] ir;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic        nps;
    logic [31:0] tgt;
    logic        rdy;
    logic        stall;
    logic        clr;
    logic        frc;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, input logic nps, input logic [31:0] tgt,
                     input logic rdy, input logic stall, input logic clr, input logic frc,
                     input logic [31:0] epc, input logic ereq, input logic etrap,
                     input logic [31:0] eta, input logic [31:0] eir);
    vec_t v;
    v.rst_n   = r;
    v.nps     = nps;
    v.tgt     = tgt;
    v.rdy     = rdy;
    v.stall   = stall;
    v.clr     = clr;
    v.frc     = frc;
    v.e.pc    = epc;
    v.e.req   = ereq;
    v.e.trap  = etrap;
    v.e.taddr = eta;
    v.e.ir    = eir;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", name, row, act, want);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares it with the DUT outputs.
  int row_mon = 0;
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("pc",        row_mon, bus.pc,             e.pc);
      chk("pc_plus4",  row_mon, bus.pc_plus4,       e.pc + 32'd4);
      chk("imem_req",  row_mon, 32'(bus.imem_req),  32'(e.req));
      chk("trap",      row_mon, 32'(bus.trap),      32'(e.trap));
      chk("trap_addr", row_mon, bus.trap_addr,      e.taddr);
      chk("instret",   row_mon, bus.instret,        e.ir);
      row_mon++;
    end
  end

  // Driver: applies one vector per cycle just after the rising edge.
  initial begin
    vec_t v;
    int   waited;
    bus.next_pc_src = 1'b0;
    bus.alu_target  = 32'h0;
    bus.imem_ready  = 1'b0;
    bus.stall       = 1'b0;
    bus.trap_clear  = 1'b0;

    //   rst nps tgt            rdy stl clr frc | pc            req trp taddr         instret
    add(0, 0, 32'h0,          0, 0, 0, 0,   32'h0,         0, 0, 32'h0,   32'd0);  // held in reset
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'h0,         0, 0, 32'h0,   32'd0);  // IDLE after release
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'h0,         1, 0, 32'h0,   32'd0);  // FETCH, seq
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'h4,         1, 0, 32'h0,   32'd1);
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'h8,         1, 0, 32'h0,   32'd2);
    add(1, 1, 32'h40,         1, 0, 0, 0,   32'hC,         1, 0, 32'h0,   32'd3);  // branch to 0x40
    add(1, 1, 32'h81,         1, 0, 0, 0,   32'h40,        1, 0, 32'h0,   32'd4);  // bit0 cleared
    add(1, 0, 32'h0,          0, 0, 0, 0,   32'h80,        1, 0, 32'h0,   32'd5);  // imem not ready
    add(1, 0, 32'h0,          0, 0, 0, 0,   32'h80,        1, 0, 32'h0,   32'd5);
    add(1, 0, 32'h0,          1, 1, 0, 0,   32'h80,        1, 0, 32'h0,   32'd5);  // stall beats ready
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'h80,        1, 0, 32'h0,   32'd5);  // commit
    add(1, 1, 32'h206,        1, 0, 0, 0,   32'h84,        1, 0, 32'h0,   32'd6);  // misaligned target
    add(1, 1, 32'h40,         1, 0, 0, 0,   32'h84,        0, 1, 32'h206, 32'd7);  // TRAP ignores inputs
    add(1, 0, 32'h0,          1, 0, 1, 0,   32'h84,        0, 1, 32'h206, 32'd7);  // trap_clear
    add(1, 0, 32'h0,          0, 0, 1, 0,   32'h100,       1, 0, 32'h206, 32'd7);  // clear outside TRAP
    add(1, 1, 32'hFFFF_FFFD,  1, 0, 0, 0,   32'h100,       1, 0, 32'h206, 32'd7);  // jump to top word
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'hFFFF_FFFC, 1, 0, 32'h206, 32'd8);  // wrap pc
    add(1, 0, 32'h0,          1, 1, 0, 0,   32'h0,         1, 0, 32'h206, 32'd9);
    add(1, 0, 32'h0,          1, 0, 0, 1,   32'h0,         1, 0, 32'h206, 32'hFFFF_FFFF); // preload counter
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'h4,         1, 0, 32'h206, 32'd0);  // counter wrapped
    add(0, 0, 32'h0,          1, 0, 0, 0,   32'h0,         0, 0, 32'h0,   32'd0);  // async reset mid-FETCH
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'h0,         0, 0, 32'h0,   32'd0);
    add(1, 0, 32'h0,          1, 0, 0, 0,   32'h0,         1, 0, 32'h0,   32'd0);
    add(1, 0, 32'h0,          0, 0, 0, 0,   32'h4,         1, 0, 32'h0,   32'd1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      if (v.frc) force dut.instret_q = 32'hFFFF_FFFF;
      rst_n           = v.rst_n;
      bus.next_pc_src = v.nps;
      bus.alu_target  = v.tgt;
      bus.imem_ready  = v.rdy;
      bus.stall       = v.stall;
      bus.trap_clear  = v.clr;
      expq.push_back(v.e);
      if (v.frc) begin
        #1;
        release dut.instret_q;
      end
    end

    waited = 0;
    while (expq.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
